// File: rtl/tick_scheduler_if.sv
// Bus bundle for the tick scheduler: run control, divisor handshake,
// per-process requests and the tick/grant/divided-clock outputs.
interface tick_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DIV_W   = 24
);
   logic               enable;
   logic               cfg_valid;
   logic [DIV_W-1:0]   cfg_div;
   logic               cfg_ready;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic               tick;
   logic               clk_out;

   // Driver side: the process network / controller.
   modport master (
      output enable, cfg_valid, cfg_div, req,
      input  cfg_ready, grant, tick, clk_out
   );

   // Scheduler side.
   modport slave (
      input  enable, cfg_valid, cfg_div, req,
      output cfg_ready, grant, tick, clk_out
   );
endinterface

// File: rtl/tick_scheduler.sv
// Programmable tick generator with run-time reloadable divisor, a
// registered divided clock and a round-robin grant of each tick to one
// requesting process.
module tick_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DIV_W       = 24,
   parameter int DEFAULT_DIV = 5_000_000
) (
   input  logic             clk_in,
   input  logic             reset_n,
   tick_scheduler_if.slave  bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [DIV_W-1:0]   counter_reg, counter_next;
   logic [DIV_W-1:0]   div_reg, div_next;
   logic [DIV_W-1:0]   pending_reg, pending_next;
   logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic               tick_reg, tick_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic               clk_out_reg, clk_out_next;

   logic               cfg_ready;
   logic               running;
   logic               wrap;
   logic               cfg_accept;
   logic [DIV_W-1:0]   cfg_clamped;

   // Arbitration candidates: offset gi from rr_ptr+1, wrapped mod NUM_REQ.
   logic [PTR_W:0]     cand_sum [NUM_REQ];
   logic [PTR_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] win_onehot;

   assign running     = (state_reg != IDLE);
   assign wrap        = running && (counter_reg == div_reg - DIV_W'(1));
   assign cfg_accept  = bus.cfg_valid && cfg_ready;
   // Divisors below 2 would make the wrap compare degenerate, so floor at 2.
   assign cfg_clamped = (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi + 1);
         assign cand_idx[gi] = (cand_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                             ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(NUM_REQ))
                             : PTR_W'(cand_sum[gi]);
         assign cand_hit[gi] = bus.req[cand_idx[gi]];
      end
   endgenerate

   // Pick the nearest requester after the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && cand_hit[i]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[i];
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign win_onehot[gi] = win_found && (win_idx == PTR_W'(gi));
      end
   endgenerate

   // State register.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: enable drops to IDLE from anywhere, a divisor
   // offered while running waits in PEND until the next wrap.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.enable) state_next = RUN;
         end
         RUN: begin
            if (!bus.enable)     state_next = IDLE;
            else if (cfg_accept) state_next = PEND;
         end
         PEND: begin
            if (!bus.enable) state_next = IDLE;
            else if (wrap)   state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: only one divisor can be held at a time.
   always_comb begin
      cfg_ready = (state_reg != PEND);
   end

   // Datapath next values: counter, divisor, pending slot, tick, grant.
   always_comb begin
      counter_next = '0;
      div_next     = div_reg;
      pending_next = pending_reg;
      rr_ptr_next  = rr_ptr_reg;
      tick_next    = 1'b0;
      grant_next   = '0;

      if (running && bus.enable) begin
         if (wrap) begin
            tick_next  = 1'b1;
            grant_next = win_onehot;
            if (win_found) rr_ptr_next = win_idx;
         end else begin
            counter_next = counter_reg + DIV_W'(1);
         end
      end

      case (state_reg)
         IDLE: begin
            if (cfg_accept) div_next = cfg_clamped;
         end
         RUN: begin
            // When stopping, an accepted divisor goes straight in: there is
            // no period in flight that still needs the old one.
            if (cfg_accept) begin
               if (bus.enable) pending_next = cfg_clamped;
               else            div_next     = cfg_clamped;
            end
         end
         PEND: begin
            // The wrapping period used the old divisor; the new one starts now.
            if (!bus.enable || wrap) div_next = pending_reg;
         end
         default: ;
      endcase

      // High phase covers the upper half of the count, longer for odd divisors.
      clk_out_next = (state_next != IDLE) && (counter_next >= (div_next >> 1));
   end

   // Datapath registers.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         counter_reg <= '0;
         div_reg     <= DIV_W'(DEFAULT_DIV);
         pending_reg <= '0;
         rr_ptr_reg  <= PTR_W'(NUM_REQ - 1);
         tick_reg    <= 1'b0;
         grant_reg   <= '0;
         clk_out_reg <= 1'b0;
      end else begin
         counter_reg <= counter_next;
         div_reg     <= div_next;
         pending_reg <= pending_next;
         rr_ptr_reg  <= rr_ptr_next;
         tick_reg    <= tick_next;
         grant_reg   <= grant_next;
         clk_out_reg <= clk_out_next;
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.tick      = tick_reg;
   assign bus.grant     = grant_reg;
   assign bus.clk_out   = clk_out_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a divisor of 4 at reset.
module tb_tick_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DIV_W   = 24;

   logic clk;
   logic reset_n;
   int   passes;
   int   total;
   int   fails;

   tick_scheduler_if #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W)) bus ();

   tick_scheduler #(
      .NUM_REQ(NUM_REQ),
      .DIV_W(DIV_W),
      .DEFAULT_DIV(4)
   ) dut (
      .clk_in (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step until tick rises; checks cycle count, grant, and no stray grant.
   task automatic run_to_tick(input string tag, input int exp_n, input logic [3:0] exp_grant);
      int n;
      logic stray;
      n = 0;
      stray = 1'b0;
      do begin
         step();
         n++;
         if (bus.tick !== 1'b1 && bus.grant !== 4'b0000) stray = 1'b1;
      end while (bus.tick !== 1'b1 && n < 64);
      chk({tag, "_period"}, 32'(n), 32'(exp_n));
      chk({tag, "_tick"}, 32'(bus.tick), 32'd1);
      chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
      chk({tag, "_no_stray_grant"}, 32'(stray), 32'd0);
      $display("tick %s: period=%0d grant=%b", tag, n, bus.grant);
   endtask

   initial begin
      passes = 0;
      total  = 0;
      fails  = 0;
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_div   = '0;
      bus.req       = '0;
      step();
      step();
      chk("rst_tick", 32'(bus.tick), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);

      // 1: div 4, req=0; tick on 5th cycle after enable then every 4.
      reset_n    = 1'b1;
      bus.enable = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("t1_tick_%0d", k), 32'(bus.tick),
             32'((k >= 5) && ((k - 1) % 4 == 0)));
         chk($sformatf("t1_clk_%0d", k), 32'(bus.clk_out), 32'(((k - 1) % 4) >= 2));
         chk($sformatf("t1_grant_%0d", k), 32'(bus.grant), 32'd0);
         $display("cycle %0d: tick=%b clk_out=%b grant=%b", k, bus.tick, bus.clk_out, bus.grant);
      end

      // 2: all requesting -> rotate from index 0.
      bus.req = 4'b1111;
      run_to_tick("t2_a", 4, 4'b0001);
      run_to_tick("t2_b", 4, 4'b0010);
      run_to_tick("t2_c", 4, 4'b0100);
      run_to_tick("t2_d", 4, 4'b1000);
      run_to_tick("t2_e", 4, 4'b0001);

      // 3: sparse requests, then an empty tick that keeps the pointer.
      bus.req = 4'b0101;
      run_to_tick("t3_a", 4, 4'b0100);
      run_to_tick("t3_b", 4, 4'b0001);
      run_to_tick("t3_c", 4, 4'b0100);
      bus.req = 4'b0000;
      run_to_tick("t3_empty", 4, 4'b0000);
      bus.req = 4'b1111;
      run_to_tick("t3_resume", 4, 4'b1000);

      // 4: reload mid-period; current period stays 4, next is 6.
      step();
      chk("t4_between_tick", 32'(bus.tick), 32'd0);
      chk("t4_between_grant", 32'(bus.grant), 32'd0);
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = 24'd6;
      chk("t4_ready_before", 32'(bus.cfg_ready), 32'd1);
      step();
      bus.cfg_valid = 1'b0;
      chk("t4_ready_pend", 32'(bus.cfg_ready), 32'd0);
      run_to_tick("t4_old", 2, 4'b0001);
      chk("t4_ready_after", 32'(bus.cfg_ready), 32'd1);
      run_to_tick("t4_new", 6, 4'b0010);

      // 5: clamp of 1 and 0 to divisor 2.
      bus.enable = 1'b0;
      bus.req    = 4'b0000;
      step();
      chk("t5_idle_tick", 32'(bus.tick), 32'd0);
      chk("t5_idle_clk", 32'(bus.clk_out), 32'd0);
      chk("t5_idle_ready", 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = 24'd1;
      step();
      bus.cfg_valid = 1'b0;
      bus.enable    = 1'b1;
      step();
      run_to_tick("t5_div1", 2, 4'b0000);
      chk("t5_clk_lo0", 32'(bus.clk_out), 32'd0);
      step();
      chk("t5_clk_hi", 32'(bus.clk_out), 32'd1);
      chk("t5_tick_lo", 32'(bus.tick), 32'd0);
      step();
      chk("t5_clk_lo1", 32'(bus.clk_out), 32'd0);
      chk("t5_tick_hi", 32'(bus.tick), 32'd1);
      bus.enable = 1'b0;
      step();
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = 24'd0;
      step();
      bus.cfg_valid = 1'b0;
      bus.enable    = 1'b1;
      step();
      run_to_tick("t5_div0", 2, 4'b0000);
      step();
      chk("t5_div0_clk_hi", 32'(bus.clk_out), 32'd1);

      // 6a: reset with a divisor pending drops it and restores defaults.
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = 24'd7;
      step();
      bus.cfg_valid = 1'b0;
      chk("t6_ready_pend", 32'(bus.cfg_ready), 32'd0);
      reset_n = 1'b0;
      step();
      chk("t6_rst_tick", 32'(bus.tick), 32'd0);
      chk("t6_rst_grant", 32'(bus.grant), 32'd0);
      chk("t6_rst_clk", 32'(bus.clk_out), 32'd0);
      chk("t6_rst_ready", 32'(bus.cfg_ready), 32'd1);
      reset_n = 1'b1;
      bus.req = 4'b1111;
      step();
      run_to_tick("t6_def_a", 4, 4'b0001);
      run_to_tick("t6_def_b", 4, 4'b0010);

      // 6b: stopping in PEND commits the pending divisor; pointer kept.
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = 24'd3;
      step();
      bus.cfg_valid = 1'b0;
      chk("t6b_ready_pend", 32'(bus.cfg_ready), 32'd0);
      bus.enable = 1'b0;
      step();
      chk("t6b_idle_ready", 32'(bus.cfg_ready), 32'd1);
      chk("t6b_idle_tick", 32'(bus.tick), 32'd0);
      chk("t6b_idle_grant", 32'(bus.grant), 32'd0);
      chk("t6b_idle_clk", 32'(bus.clk_out), 32'd0);
      bus.enable = 1'b1;
      step();
      run_to_tick("t6b_div3", 3, 4'b0100);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
